mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving three requesters turns on one shared 8-bit memory port.
// Each transaction runs IDLE -> ACCESS (until mem_ready or TIMEOUT wait cycles) -> COMPLETE -> IDLE.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  we_in,
    input  logic [23:0] addr_in,
    input  logic [23:0] wdata_in,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    // Wait count seen in the final permitted ACCESS cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] last_q, last_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [1:0] win_idx;

    // Search starts just after the last served requester, wrapping 0->1->2->0.
    always_comb begin
        win_idx = 2'd0;
        case (last_q)
            2'd0:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = 3'b001 << win_idx;
                    we_d    = we_in[win_idx];
                    addr_d  = addr_in[{win_idx, 3'b000} +: 8];
                    wdata_d = wdata_in[{win_idx, 3'b000} +: 8];
                    wait_d  = 8'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = COMPLETE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        err_d   = 1'b1;
                        state_d = COMPLETE;
                    end
                end
            end
            COMPLETE: begin
                last_d  = gnt_q[0] ? 2'd0 : (gnt_q[1] ? 2'd1 : 2'd2);
                gnt_d   = 3'b000;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 3'b000;
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            wait_q  <= 8'd0;
            last_q  <= 2'd2;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = (state_q == COMPLETE) ? gnt_q : 3'b000;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
